// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU command sequencer.
//   state_t      - sequencer FSM state encoding
//   OP_HALT      - opcode that parks the sequencer until reset
//   *_MSB/*_LSB  - bit positions of the 12-bit command fields
//   NUM_REGS     - register file depth; REG_OUT is the result-only register
package alu_seq_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;

    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int unsigned OPC_MSB = 11;
    localparam int unsigned OPC_LSB = 9;
    localparam int unsigned A1_MSB  = 8;
    localparam int unsigned A1_LSB  = 6;
    localparam int unsigned A2_MSB  = 5;
    localparam int unsigned A2_LSB  = 3;
    localparam int unsigned A3_MSB  = 2;
    localparam int unsigned A3_LSB  = 0;

    localparam int unsigned NUM_REGS = 8;
    localparam logic [2:0]  REG_OUT  = 3'd7;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 8 x DATA_W register file for the ALU sequencer.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset (clears all regs)
//   host_we_i/addr/data     host preload write; writes to r7 are dropped
//   res_we_i/addr/data      ALU writeback; always updates r7, plus dest if dest != r7
//   ra_*, rb_*              combinational operand read ports
//   dbg_*                   combinational debug read port
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_we_i,
    input  logic [2:0]        host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              res_we_i,
    input  logic [2:0]        res_addr_i,
    input  logic [DATA_W-1:0] res_data_i,
    input  logic [2:0]        ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [2:0]        rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [2:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Host and result writes are never enabled together (the sequencer gates
    // host writes to IDLE/HALTED and writeback to WAIT); the result wins anyway.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (res_we_i) begin
            regs_q[REG_OUT] <= res_data_i;
            if (res_addr_i != REG_OUT) begin
                regs_q[res_addr_i] <= res_data_i;
            end
        end else if (host_we_i && (host_addr_i != REG_OUT)) begin
            regs_q[host_addr_i] <= host_data_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue command sequencer in front of the atomic ALU.
// Accepts 12-bit commands {opcode, src_a, src_b, dest} on cmd_valid/cmd_ready,
// fetches operands, pulses alu_start, waits for alu_done and writes y back.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/command  command handshake
//   alu_op_code, data_a, data_b, alu_start   registered ALU request
//   alu_done, y               ALU completion and result
//   wr_en, wr_addr, wr_data   host register preload (IDLE/HALTED only)
//   rd_addr, rd_data          combinational debug read
//   busy, halted, ops_done, err  status
// Build option: define ALU_SEQ_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT
// cycles); otherwise WAIT holds indefinitely and err is tied low.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       command,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] y,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       ops_done,
    output logic              err
);

    state_t            state_q;
    logic [2:0]        dest_q;
    logic              host_we;
    logic              res_we;
    logic [2:0]        cmd_opc;
    logic [2:0]        cmd_a1;
    logic [2:0]        cmd_a2;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign cmd_opc = command[OPC_MSB:OPC_LSB];
    assign cmd_a1  = command[A1_MSB:A1_LSB];
    assign cmd_a2  = command[A2_MSB:A2_LSB];

    assign host_we = wr_en && ((state_q == IDLE) || (state_q == HALTED));
    assign res_we  = (state_q == WAIT) && alu_done;

    alu_seq_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk_i       (clk),
        .rst_i       (rst),
        .host_we_i   (host_we),
        .host_addr_i (wr_addr),
        .host_data_i (wr_data),
        .res_we_i    (res_we),
        .res_addr_i  (dest_q),
        .res_data_i  (y),
        .ra_addr_i   (cmd_a1),
        .ra_data_o   (ra_data),
        .rb_addr_i   (cmd_a2),
        .rb_data_o   (rb_data),
        .dbg_addr_i  (rd_addr),
        .dbg_data_o  (rd_data)
    );

    // Operands are captured on the accept edge, so a host write landing on the
    // same edge is forwarded to keep "write first, then ISSUE reads it".
    always_comb begin
        fwd_a = ra_data;
        fwd_b = rb_data;
        if (host_we && (wr_addr != REG_OUT)) begin
            if (wr_addr == cmd_a1) fwd_a = wr_data;
            if (wr_addr == cmd_a2) fwd_b = wr_data;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;
    logic          err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            alu_op_code <= '0;
            data_a      <= '0;
            data_b      <= '0;
            alu_start   <= 1'b0;
            ops_done    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        dest_q <= command[A3_MSB:A3_LSB];
                        if (cmd_opc == OP_HALT) begin
                            state_q <= HALTED;
                        end else begin
                            state_q     <= ISSUE;
                            alu_op_code <= cmd_opc;
                            data_a      <= fwd_a;
                            data_b      <= fwd_b;
                            alu_start   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    alu_start <= 1'b0;
                    state_q   <= WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                    timer_q   <= '0;
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        ops_done <= ops_done + 16'd1;
                        state_q  <= IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
`endif
                    end
                end
                HALTED: state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);
    assign halted    = (state_q == HALTED);

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command sequencer for the atomic ALU. It takes 12-bit commands over a valid/ready handshake and holds the 8 x 32-bit register file. For each command it fetches two operands, starts the ALU, waits for completion and writes the result back. It sits between the host/command source and the ALU and replaces ad-hoc operand muxing with a single-issue, handshaked pipeline.

## Interface
Parameters:
- DATA_W, 32, operand/register width
- TIMEOUT, 64, ALU watchdog limit in cycles (only used with ALU_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept
- command  in  12  [11:9] opcode, [8:6] addr1 (src A), [5:3] addr2 (src B), [2:0] addr3 (dest)
- alu_op_code  out  3  opcode to ALU
- data_a, data_b  out  DATA_W  operands to ALU
- alu_start  out  1  one-cycle start pulse
- alu_done  in  1  ALU result valid
- y  in  DATA_W  ALU result
- wr_en, wr_addr[2:0], wr_data[DATA_W]  in  host register preload port
- rd_addr  in  3  debug read address
- rd_data  out  DATA_W  regs[rd_addr], combinational
- busy  out  1  state != IDLE and != HALTED
- halted  out  1  HALT executed
- ops_done  out  16  completed-op counter, wraps 0xFFFF→0x0000
- err  out  1  sticky watchdog error

## Operation
- Register file: r0–r6 are general purpose. r7 is output-only: it holds the last ALU result, is readable as a source, and host writes to it are ignored.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command. Opcode 3'b111 → HALTED; any other opcode → ISSUE.
  - ISSUE: drive data_a=regs[addr1], data_b=regs[addr2] and alu_op_code; alu_start=1. Go to WAIT.
  - WAIT: hold data_a, data_b and alu_op_code stable. On alu_done, write y to r7; if addr3 != 7, also write y to regs[addr3]. Increment ops_done and go to IDLE.
  - HALTED: cmd_ready=0, halted=1. Only rst exits this state.
- alu_done is sampled only in WAIT and ignored in all other states.
- Host write is honored only in IDLE or HALTED. If a host write and a command accept land on the same edge, the write lands first, and ISSUE reads the new value.
- Source addr1==addr2 is legal. Dest equal to a source is legal, because operands are already held.

## Timing
- Reset values: state IDLE, all regs 0, alu_start 0, data_a/data_b 0, alu_op_code 0, ops_done 0, err 0, halted 0.
- cmd_ready = (state==IDLE) && !rst.
- Minimum command latency: accept edge → ISSUE cycle (alu_start high) → WAIT. Writeback happens on the edge where alu_done=1 in WAIT. IDLE follows on the next cycle, so an op takes 3 cycles minimum.
- The ALU must not assert alu_done in the same cycle as alu_start.
- Back-to-back commands see the previous result (read-after-write is safe): writeback completes before the next ISSUE.
- rst mid-operation aborts immediately. The in-flight result is discarded, and a late alu_done after reset is ignored.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - WAIT counts cycles. If TIMEOUT cycles pass without alu_done, err is set (sticky until rst) and the FSM returns to IDLE with no writeback.
  - ops_done is not incremented on a timeout.
- ALU_SEQ_TIMEOUT_EN undefined: WAIT holds indefinitely, and err is tied to 0.

## Structure
- Package alu_seq_pkg:
  - state enum {IDLE, ISSUE, WAIT, HALTED}
  - OP_HALT=3'b111
  - command field position constants
  - NUM_REGS=8, REG_OUT=7
- Sub-module alu_seq_regfile: 8 x DATA_W storage, async reset, two combinational read ports plus the debug port, one write port with the r7 write path. The FSM, handshake and counters stay in alu_sequencer.

## Test plan
- Preload: host writes r1=5, r2=7. Command {3'b000,1,2,3} with the ALU model returning 12 two cycles after start → alu_start seen once with data_a=5, data_b=7; r3=12, r7=12, ops_done=1.
- Dest r7: command addr3=7, y=0xDEAD → r7=0xDEAD and r0–r6 unchanged. Host write to r7 → ignored.
- HALT: command 3'b111 → halted=1, cmd_ready=0. alu_start never pulses, further cmd_valid is ignored, and rst clears halted.
- Reset during WAIT: assert rst, then drive alu_done after release → regs all 0, ops_done=0, no writeback.
- Back-to-back: r1=r1+r1 issued twice with r1=3 → r1=6, then r1=12. Each op takes 3 cycles with single-cycle ALU latency.
- With ALU_SEQ_TIMEOUT_EN and TIMEOUT=64: never assert alu_done → after 64 WAIT cycles err=1, state IDLE, dest unchanged, ops_done unchanged.
